uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one uart_transmitter1 instance between NUM_REQ byte requesters (FIFO read ports, status reporters).
- Accepts bytes over a per-requester valid/ready handshake.
- Launches each byte with a one-cycle o_Tx_DV pulse and waits for the frame to complete before launching the next.
- Allows bounded bursts, so multi-byte messages stay contiguous on the line.
- Recovers via a watchdog if the transmitter never reports done.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLKS_PER_BIT, 87, transmitter clocks per UART bit (10 MHz / 115200)
MAX_BURST, 4, max consecutive bytes granted to one requester before re-arbitration (>=1)
TIMEOUT_CLKS, 12*CLKS_PER_BIT, clocks allowed from launch to i_Tx_Done rising edge

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
i_Req_Valid  in  NUM_REQ  bit k: requester k has a byte
i_Req_Data  in  8*NUM_REQ  byte k at [8k+7:8k]; held stable while valid and not ready
o_Req_Ready  out  NUM_REQ  one-hot; transfer when valid&ready in the same cycle
o_Tx_DV  out  1  registered one-cycle launch pulse to transmitter i_Tx_DV
o_Tx_Byte  out  8  registered byte to transmitter i_Tx_Byte; valid while o_Tx_DV=1
i_Tx_Active  in  1  from transmitter o_Tx_Active
i_Tx_Done  in  1  from transmitter o_Tx_Done (high 2 cycles per frame)
o_Grant_Id  out  clog2(NUM_REQ)  current grantee; meaningful while o_Busy=1
o_Busy  out  1  state != IDLE
o_Timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
Reset values (i_Reset_n=0 at a clock edge):
- All outputs 0; state=IDLE; burst_cnt=0; timer=0.
- last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame aborts scheduling immediately. The transmitter is not reset; the IDLE guard covers its remaining activity.

IDLE:
- Guard: no launch while i_Tx_Active=1 or i_Tx_Done=1.
- Otherwise, if any i_Req_Valid bit is set, select the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
- Register the winner in o_Grant_Id and go to LAUNCH.

LAUNCH (exactly 1 cycle):
- o_Req_Ready[grant]=1 (combinational from state/grant); the handshake completes here.
- Next edge: o_Tx_DV<=1, o_Tx_Byte<=i_Req_Data[grant], burst_cnt++, timer<=0; go to WAIT_DONE.
- If i_Req_Valid[grant] has dropped in this cycle (protocol violation), return to IDLE with no DV.

WAIT_DONE:
- o_Tx_DV returns to 0 after its one cycle; timer increments every cycle.
- Rising edge of i_Tx_Done (registered previous value used for edge detect): go to GAP.
- timer==TIMEOUT_CLKS-1 with no edge: pulse o_Timeout, set last_grant=grant, burst_cnt=0, go to IDLE.
- Edge detection ensures the 2-cycle done level counts once.

GAP (1 cycle): required because the transmitter spends one cycle in CLEANUP after done rises. Exit rules:
- If i_Req_Valid[grant]=1 and burst_cnt<MAX_BURST: go to LAUNCH with the same grant.
- Otherwise: last_grant<=grant, burst_cnt<=0, go to IDLE.

Latency and throughput:
- Valid seen in IDLE at cycle 0: ready in cycle 1, o_Tx_DV in cycle 2.
- Back-to-back burst bytes: o_Tx_DV occurs 3 cycles after the done rising edge.

Boundary conditions:
- Grant wraps from NUM_REQ-1 to 0.
- A single active requester is re-granted after each burst (no idle bubble beyond IDLE→LAUNCH).
- New valids arriving during a burst do not preempt it.
- MAX_BURST=1 gives pure per-byte round robin.
- Done pulse arriving while in IDLE (stray or post-reset) is ignored.
- Timer width is clog2(TIMEOUT_CLKS+1) and it saturates.

Test Plan:
- Reset, then req0 valid with 0xA5 -> ready0 pulses at cycle 1; o_Tx_DV one cycle at cycle 2 with o_Tx_Byte=0xA5; serial line carries 0xA5 LSB-first; o_Busy low after GAP.
- All 4 requesters valid with 1 byte each (0x11,0x22,0x33,0x44) -> launch order 0,1,2,3; exactly one DV per done edge; o_Grant_Id 0→3.
- Req1 holds 6 bytes, req2 holds 1 byte, MAX_BURST=4 -> order 1,1,1,1,2,1,1; no DV while i_Tx_Active=1.
- Transmitter model never asserts done -> o_Timeout pulses exactly TIMEOUT_CLKS cycles after DV; next requester then granted; no ready lost or duplicated.
- i_Reset_n low for 1 cycle during the data bits of a frame -> outputs zero; no DV until the transmitter finishes its frame (i_Tx_Active and i_Tx_Done both 0); req0 is then served first.
- Check the handshake throughout: every valid&ready byte is transmitted exactly once; ready is never asserted outside LAUNCH.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// requesters. A grantee may send up to MAX_BURST bytes back to back so that
// multi-byte messages stay contiguous on the line. A watchdog recovers the
// scheduler if the transmitter never reports done.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int MAX_BURST    = 4,
  parameter int TIMEOUT_CLKS = 12*CLKS_PER_BIT
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic [NUM_REQ-1:0]         i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]       i_Req_Data,
  output logic [NUM_REQ-1:0]         o_Req_Ready,
  output logic                       o_Tx_DV,
  output logic [7:0]                 o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
  output logic                       o_Busy,
  output logic                       o_Timeout
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST+1);
  localparam int TW = $clog2(TIMEOUT_CLKS+1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  localparam logic [BW-1:0] MAXB    = BW'(MAX_BURST);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS-1);
  localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CLKS);

  logic [1:0]              state;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           pick;
  logic                    pick_vld;
  logic [GW:0]             idx;
  logic [BW-1:0]           burst_cnt;
  logic [TW-1:0]           timer;
  logic                    done_q;
  logic                    done_rise;
  logic [NUM_REQ-1:0][7:0] req_byte;

  assign req_byte   = i_Req_Data;
  assign o_Grant_Id = grant;
  assign o_Busy     = (state != IDLE);
  // done is a 2-cycle level; only its rising edge ends a frame
  assign done_rise  = i_Tx_Done & ~done_q;

  // ready is one-hot on the grantee, and only during the single LAUNCH cycle
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_rdy
    assign o_Req_Ready[k] = (state == LAUNCH) && (grant == GW'(k));
  end

  // round-robin pick: first valid requester after last_grant, with wrap.
  // Scan from farthest to nearest so the nearest valid one is the last write.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = {1'b0, last_grant} + (GW+1)'(i);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (i_Req_Valid[idx[GW-1:0]]) begin
        pick     = idx[GW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // scheduler FSM, launch pulse, burst counter and watchdog
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ-1);
      burst_cnt  <= '0;
      timer      <= '0;
      done_q     <= 1'b0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= '0;
      o_Timeout  <= 1'b0;
    end else begin
      done_q    <= i_Tx_Done;
      o_Tx_DV   <= 1'b0;
      o_Timeout <= 1'b0;
      case (state)
        IDLE: begin
          // the transmitter may still be finishing a frame we no longer own
          if (!i_Tx_Active && !i_Tx_Done && pick_vld) begin
            grant <= pick;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (i_Req_Valid[grant]) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= req_byte[grant];
            burst_cnt <= burst_cnt + 1'b1;
            timer     <= '0;
            state     <= WAIT_DONE;
          end else begin
            // requester withdrew mid-handshake: drop the burst, no launch
            burst_cnt <= '0;
            state     <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (timer != TO_SAT) timer <= timer + 1'b1;
          if (done_rise) begin
            state <= GAP;
          end else if (timer == TO_LAST) begin
            o_Timeout  <= 1'b1;
            last_grant <= grant;
            burst_cnt  <= '0;
            state      <= IDLE;
          end
        end
        GAP: begin
          // transmitter is in its cleanup cycle; decide whether the burst goes on
          if (i_Req_Valid[grant] && (burst_cnt < MAXB)) begin
            state <= LAUNCH;
          end else begin
            last_grant <= grant;
            burst_cnt  <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
